// File: rtl/keypad_pkg.sv
// Shared types, sizes and the key-code map for the 4x4 matrix keypad scanner.
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE_PRESS,
        HELD,
        DEBOUNCE_RELEASE
    } state_t;

    // Indexed [row][col]; the bottom row carries E,0,F,D like the printed keypad.
    localparam logic [3:0] KEYMAP [NUM_ROWS][NUM_COLS] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'hE, 4'h0, 4'hF, 4'hD}
    };

    function automatic logic [3:0] keymap(input logic [1:0] r, input logic [1:0] c);
        return KEYMAP[r][c];
    endfunction

    // One-hot-low column drive for column index c.
    function automatic logic [NUM_COLS-1:0] col_drive(input logic [1:0] c);
        return ~(NUM_COLS'(1) << c);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs; resets to all-ones (idle pull-up level).
module sync_2ff #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner: column scan, press/release debounce, and a two-digit history.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_CYCLES     = 48000,
    parameter int DEBOUNCE_CYCLES = 960000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_ROWS-1:0] row,
    output logic [NUM_COLS-1:0] col,
    output logic                key_valid,
    output logic [3:0]          key_code,
    output logic                key_held,
    output logic [3:0]          digit_left,
    output logic [3:0]          digit_right
);

    localparam int SCAN_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam int DEB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYCLES - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_ROWS-1:0] row_s;
    state_t              state;
    logic [1:0]          idx;
    logic [1:0]          cap_row;
    logic [SCAN_W-1:0]   scan_cnt;
    logic [DEB_W-1:0]    deb_cnt;

    logic [NUM_ROWS-1:0] low;
    logic                single_low;
    logic [1:0]          low_idx;
    logic [NUM_ROWS-1:0] press_pattern;

    sync_2ff #(.WIDTH(NUM_ROWS)) u_row_sync (
        .clk   (clk),
        .reset (reset),
        .d     (row),
        .q     (row_s)
    );

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        low        = ~row_s;
        single_low = (low != '0) && ((low & (low - NUM_ROWS'(1))) == '0);
        low_idx    = '0;
        for (int i = NUM_ROWS - 1; i >= 0; i--) begin
            if (low[i]) low_idx = 2'(i);
        end
        press_pattern = ~(NUM_ROWS'(1) << cap_row);
    end

    // Counters only advance below their terminal value, so they cannot wrap inside a state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= SCAN;
            idx         <= '0;
            cap_row     <= '0;
            scan_cnt    <= '0;
            deb_cnt     <= '0;
            col         <= 4'b1110;
            key_valid   <= 1'b0;
            key_code    <= '0;
            key_held    <= 1'b0;
            digit_left  <= '0;
            digit_right <= '0;
        end else begin
            key_valid <= 1'b0;
            unique case (state)
                SCAN: begin
                    if (scan_cnt == SCAN_LAST) begin
                        scan_cnt <= '0;
                        if (single_low) begin
                            cap_row <= low_idx;
                            deb_cnt <= '0;
                            state   <= DEBOUNCE_PRESS;
                        end else begin
                            idx <= idx + 2'd1;
                            col <= col_drive(idx + 2'd1);
                        end
                    end else begin
                        scan_cnt <= scan_cnt + SCAN_W'(1);
                    end
                end
                DEBOUNCE_PRESS: begin
                    if (row_s != press_pattern) begin
                        scan_cnt <= '0;
                        deb_cnt  <= '0;
                        state    <= SCAN;
                    end else if (deb_cnt == DEB_LAST) begin
                        deb_cnt     <= '0;
                        key_valid   <= 1'b1;
                        key_code    <= keymap(cap_row, idx);
                        digit_left  <= digit_right;
                        digit_right <= keymap(cap_row, idx);
                        key_held    <= 1'b1;
                        state       <= HELD;
                    end else begin
                        deb_cnt <= deb_cnt + DEB_W'(1);
                    end
                end
                HELD: begin
                    if (row_s[cap_row]) begin
                        deb_cnt <= '0;
                        state   <= DEBOUNCE_RELEASE;
                    end
                end
                DEBOUNCE_RELEASE: begin
                    if (!row_s[cap_row]) begin
                        deb_cnt <= '0;
                        state   <= HELD;
                    end else if (deb_cnt == DEB_LAST) begin
                        deb_cnt  <= '0;
                        scan_cnt <= '0;
                        key_held <= 1'b0;
                        idx      <= idx + 2'd1;
                        col      <= col_drive(idx + 2'd1);
                        state    <= SCAN;
                    end else begin
                        deb_cnt <= deb_cnt + DEB_W'(1);
                    end
                end
                default: state <= SCAN;
            endcase
        end
    end

endmodule
